// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl - sequencing controller for an iterative AES-128 encryptor.
//
// Accepts plaintext/key requests, starts the external key expander only when
// the key changes (or no usable expanded key is cached), then steps an
// external combinational single-round datapath through rounds 1..NR, one
// round per cycle, and presents the ciphertext over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               request handshake
//   in_new_key, in_key, in_data     request payload (sampled on accept)
//   ks_start, ks_key                key expander start pulse and key
//   ks_finish, ks_roundkeys         expander done pulse and round keys 1..NR
//   rnd_state, rnd_key, rnd_last    inputs to the round datapath
//   rnd_result                      round datapath output
//   out_valid/out_ready, out_data   ciphertext handshake
//   key_valid                       cached expanded key is usable
//   ks_err                          one-cycle pulse on expansion timeout
module aes_enc_ctrl #(
    parameter int NR         = 10,
    parameter int KS_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_new_key,
    input  logic [127:0]        in_key,
    input  logic [127:0]        in_data,
    output logic                ks_start,
    output logic [127:0]        ks_key,
    input  logic                ks_finish,
    input  logic [128*NR-1:0]   ks_roundkeys,
    output logic [127:0]        rnd_state,
    output logic [127:0]        rnd_key,
    output logic                rnd_last,
    input  logic [127:0]        rnd_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                key_valid,
    output logic                ks_err
);

    localparam int TW = $clog2(KS_TIMEOUT + 1);
    // The counter holds the number of KEYX cycles already completed, so the
    // abort decision is taken in the KS_TIMEOUT-th KEYX cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(KS_TIMEOUT - 1);
    localparam logic [3:0]    RND_LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, KEYX, ROUND, OUTP} state_t;

    state_t        fsm_q, fsm_d;
    logic [3:0]    round_q, round_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [127:0]  key0_q, key0_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  out_data_q, out_data_d;
    logic          key_valid_q, key_valid_d;
    logic          ks_start_q, ks_start_d;
    logic          out_valid_q, out_valid_d;
    logic          ks_err_q, ks_err_d;

    // Round keys unpacked so round i maps directly to rk[i].
    logic [127:0] rk [1:NR];
    logic [127:0] rk_sel;

    for (genvar gi = 1; gi <= NR; gi++) begin : g_rk
        assign rk[gi] = ks_roundkeys[128*(NR-gi) +: 128];
    end

    always_comb begin
        rk_sel = '0;
        for (int i = 1; i <= NR; i++) begin
            if (round_q == 4'(i)) rk_sel = rk[i];
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        tmo_d       = tmo_q;
        key0_d      = key0_q;
        st_d        = st_q;
        out_data_d  = out_data_q;
        key_valid_d = key_valid_q;
        out_valid_d = out_valid_q;
        ks_start_d  = 1'b0;
        ks_err_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_new_key || !key_valid_q) begin
                        key0_d      = in_key;
                        st_d        = in_data ^ in_key;
                        key_valid_d = 1'b0;
                        tmo_d       = '0;
                        // Registered, so it is high exactly in the first KEYX cycle.
                        ks_start_d  = 1'b1;
                        fsm_d       = KEYX;
                    end else begin
                        st_d    = in_data ^ key0_q;
                        round_d = 4'd1;
                        fsm_d   = ROUND;
                    end
                end
            end
            KEYX: begin
                tmo_d = tmo_q + TW'(1);
                // ks_finish takes priority over a coincident timeout.
                if (ks_finish) begin
                    key_valid_d = 1'b1;
                    round_d     = 4'd1;
                    fsm_d       = ROUND;
                end else if (tmo_q == TMO_LAST) begin
                    ks_err_d = 1'b1;
                    fsm_d    = IDLE;
                end
            end
            ROUND: begin
                st_d    = rnd_result;
                round_d = round_q + 4'd1;
                if (round_q == RND_LAST) begin
                    out_data_d  = rnd_result;
                    out_valid_d = 1'b1;
                    round_d     = 4'd0;
                    fsm_d       = OUTP;
                end
            end
            OUTP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            tmo_q       <= '0;
            key0_q      <= '0;
            st_q        <= '0;
            out_data_q  <= '0;
            key_valid_q <= 1'b0;
            ks_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ks_err_q    <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            tmo_q       <= tmo_d;
            key0_q      <= key0_d;
            st_q        <= st_d;
            out_data_q  <= out_data_d;
            key_valid_q <= key_valid_d;
            ks_start_q  <= ks_start_d;
            out_valid_q <= out_valid_d;
            ks_err_q    <= ks_err_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign ks_start  = ks_start_q;
    assign ks_key    = key0_q;
    assign rnd_state = (fsm_q == ROUND) ? st_q   : '0;
    assign rnd_key   = (fsm_q == ROUND) ? rk_sel : '0;
    assign rnd_last  = (fsm_q == ROUND) && (round_q == RND_LAST);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign key_valid = key_valid_q;
    assign ks_err    = ks_err_q;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl - directed bench for aes_enc_ctrl. Provides a behavioural
// AES round datapath and a key-expander stub (fixed latency, or never
// finishing), and checks against FIPS-197 vectors and a small AES model.
module tb_aes_enc_ctrl;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_new_key;
    logic [127:0]    in_key, in_data;
    logic            ks_start, ks_finish;
    logic [127:0]    ks_key;
    logic [1279:0]   ks_roundkeys;
    logic [127:0]    rnd_state, rnd_key, rnd_result;
    logic            rnd_last;
    logic            out_valid, out_ready;
    logic [127:0]    out_data;
    logic            key_valid, ks_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_ks_start = 0;
    logic stub_hang;
    logic ks_pend;
    int   ks_dly;

    aes_enc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_new_key(in_new_key),
        .in_key(in_key), .in_data(in_data),
        .ks_start(ks_start), .ks_key(ks_key), .ks_finish(ks_finish),
        .ks_roundkeys(ks_roundkeys),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_last(rnd_last),
        .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_valid(key_valid), .ks_err(ks_err)
    );

    always #5 clk = ~clk;

    // ---------------- AES software model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x};
        t = t << n;
        return t[15:8];
    endfunction

    // S-box from the GF(2^8) inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv, p;
        inv = 8'h01;
        p   = b;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int j = 0; j < 16; j++) a[j] = sbox(s[127-8*j -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[r+4*c] = b[r+4*c];
            end else begin
                m[4*c+0] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
                m[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
            end
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = m[j];
        return o ^ k;
    endfunction

    // Returns {rk1, rk2, ..., rk10}.
    function automatic logic [1279:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [1279:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 1; r <= 10; r++)
            o[128*(10-r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] d);
        logic [1279:0] rks;
        logic [127:0]  s;
        rks = expand(k);
        s   = d ^ k;
        for (int r = 1; r <= 10; r++) s = aes_round(s, rks[128*(10-r) +: 128], r == 10);
        return s;
    endfunction

    // ---------------- environment ----------------
    always_comb rnd_result = aes_round(rnd_state, rnd_key, rnd_last);

    // Expander stub: ks_finish three cycles after ks_start is seen, unless hung.
    always @(posedge clk) begin
        ks_finish <= 1'b0;
        if (ks_start) begin
            n_ks_start   <= n_ks_start + 1;
            ks_pend      <= 1'b1;
            ks_dly       <= 0;
            ks_roundkeys <= expand(ks_key);
        end else if (stub_hang || !rst_n) begin
            ks_pend <= 1'b0;
        end else if (ks_pend) begin
            if (ks_dly == 2) begin
                ks_finish <= 1'b1;
                ks_pend   <= 1'b0;
            end
            ks_dly <= ks_dly + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (called at a negedge) and wait for out_valid with
    // out_ready low. Edge 0 is the accepting edge; lat_acc is the number of
    // edges after it until out_valid is seen; lat_fin counts from the edge
    // that sampled ks_finish.
    task automatic run_req(input logic [127:0] k, input logic [127:0] d, input logic nk,
                           output logic [127:0] ct, output int lat_acc, output int lat_fin,
                           output int starts, output int lasts);
        int n0;
        int fin_edge;
        bit got;
        n0 = n_ks_start;
        fin_edge = -1;
        got = 1'b0;
        lat_acc = -1;
        lat_fin = -1;
        lasts = 0;
        ct = '0;
        chk("acc_rdy", {127'h0, in_ready}, 128'h1);
        in_valid = 1'b1; in_key = k; in_data = d; in_new_key = nk;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (ks_finish) fin_edge = i + 1;
            if (rnd_last) lasts++;
            if (out_valid) begin
                got = 1'b1;
                lat_acc = i;
                ct = out_data;
            end else begin
                @(negedge clk);
            end
        end
        chk("done", {127'h0, got}, 128'h1);
        if (fin_edge >= 0) lat_fin = lat_acc - fin_edge;
        starts = n_ks_start - n0;
        $display("req key=%h pt=%h new_key=%0d ct=%h lat=%0d ks_start=%0d",
                 k, d, nk, ct, lat_acc, starts);
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs", {126'h0, out_valid, in_ready}, 128'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, exp;
        logic [1279:0] rks;
        int la, lf, st, ls, err_at;
        bit seen;

        rst_n = 1'b0; in_valid = 1'b0; in_new_key = 1'b0; in_key = '0; in_data = '0;
        out_ready = 1'b0; stub_hang = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {122'h0, in_ready, out_valid, key_valid, ks_start, ks_err, rnd_last}, 128'h20);
        chk("rst_out", out_data, '0);
        chk("rst_kskey", ks_key, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // First request after reset with in_new_key=0: expansion is forced.
        run_req(K1, P1, 1'b0, ct, la, lf, st, ls);
        chk("A_ct", ct, C1);
        chk("A_start", 128'(st), 128'd1);
        chk("A_lat_fin", 128'(lf), 128'd10);
        chk("A_last", 128'(ls), 128'd1);
        chk("A_kv", {127'h0, key_valid}, 128'h1);
        finish_out();

        // FIPS-197 C.1 with an explicit new key.
        run_req(K1, P1, 1'b1, ct, la, lf, st, ls);
        chk("B_ct", ct, C1);
        chk("B_start", 128'(st), 128'd1);
        chk("B_kv", {127'h0, key_valid}, 128'h1);
        finish_out();

        // Cached key, zero plaintext, then hold out_ready low for 5 cycles.
        run_req(K1, 128'h0, 1'b0, ct, la, lf, st, ls);
        exp = aes_enc(K1, 128'h0);
        chk("C_ct", ct, exp);
        chk("C_start", 128'(st), 128'd0);
        chk("C_lat", 128'(la), 128'd10);
        in_valid = 1'b1; in_key = K2; in_data = P2; in_new_key = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ctl", {126'h0, out_valid, in_ready}, 128'h2);
            chk("hold_data", out_data, exp);
        end
        in_valid = 1'b0;
        finish_out();

        // Key change: FIPS-197 appendix B vector.
        run_req(K2, P2, 1'b1, ct, la, lf, st, ls);
        chk("D_ct", ct, C2);
        chk("D_start", 128'(st), 128'd1);
        finish_out();

        // Expander never finishes: ks_err after 15 KEYX cycles.
        stub_hang = 1'b1;
        chk("E_rdy", {127'h0, in_ready}, 128'h1);
        in_valid = 1'b1; in_key = K1; in_data = P1; in_new_key = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        err_at = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ks_err) begin
                seen = 1'b1;
                err_at = i;
            end else begin
                @(negedge clk);
            end
        end
        $display("req key=%h pt=%h new_key=1 ks_err_edge=%0d", K1, P1, err_at);
        chk("E_err_at", 128'(err_at), 128'd15);
        chk("E_state", {126'h0, in_ready, key_valid}, 128'h2);
        @(negedge clk);
        chk("E_pulse", {127'h0, ks_err}, 128'h0);
        stub_hang = 1'b0;

        // After timeout, in_new_key=0 must still re-expand.
        run_req(K2, P2, 1'b0, ct, la, lf, st, ls);
        chk("F_ct", ct, C2);
        chk("F_start", 128'(st), 128'd1);
        finish_out();

        // Reset asserted during round 5 of a cached-key request.
        in_valid = 1'b1; in_key = K2; in_data = P1; in_new_key = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rks = expand(K2);
        chk("G_rk5", rnd_key, rks[640 +: 128]);
        chk("G_last5", {127'h0, rnd_last}, 128'h0);
        rst_n = 1'b0;
        #1;
        chk("G_rst_ctl", {122'h0, in_ready, out_valid, key_valid, ks_start, ks_err, rnd_last}, 128'h20);
        chk("G_rst_rk", rnd_key, '0);
        chk("G_rst_st", rnd_state, '0);
        chk("G_rst_out", out_data, '0);
        $display("req key=%h pt=%h new_key=0 reset_in_round5", K2, P1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(K2, P1, 1'b0, ct, la, lf, st, ls);
        chk("H_ct", ct, aes_enc(K2, P1));
        chk("H_start", 128'(st), 128'd1);
        chk("H_lat_fin", 128'(lf), 128'd10);
        finish_out();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
